// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instMem and registers the fetched
// word into the IF/ID pipeline register with a valid/ready handshake to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] EBREAK   = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        halted,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHalted
    } state_e;

    state_e      state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        halted_q, halted_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redirect_ok;
    logic        redirect_bad;
    logic        is_ebreak;
    logic        load;
    logic        drain;

    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign is_ebreak    = (inst_in == EBREAK);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides whatever the current state would do
    always_comb begin
        state_d = state_q;
        if (redirect_ok) begin
            state_d = StFetch;
        end else if (redirect_bad) begin
            state_d = StHalted;
        end else begin
            case (state_q)
                StIdle:   state_d = StFetch;
                StFetch:  if (load && is_ebreak) state_d = StHalted;
                StHalted: state_d = StHalted;
                default:  state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: load a new word into IF/ID, or drain the last one while halted
    always_comb begin
        load  = 1'b0;
        drain = 1'b0;
        if (!redirect_valid) begin
            case (state_q)
                StFetch:  load  = !id_valid_q || id_ready;
                StHalted: drain = id_valid_q && id_ready;
                default: begin
                    load  = 1'b0;
                    drain = 1'b0;
                end
            endcase
        end
    end

    // Datapath next-state
    always_comb begin
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_inst_d     = id_inst_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;
        halted_d      = halted_q;
        fetch_err_d   = fetch_err_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            // Flush IF/ID; id_pc/id_pc4 keep their last values
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
            if (redirect_ok) begin
                pc_d     = redirect_pc;
                halted_d = 1'b0;
            end else begin
                fetch_err_d = 1'b1;
                halted_d    = 1'b1;
            end
        end else if (load) begin
            id_valid_d    = 1'b1;
            id_inst_d     = inst_in;
            id_pc_d       = pc_q;
            id_pc4_d      = pc_plus4;
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + 32'd1;
            if (is_ebreak) begin
                halted_d = 1'b1;
            end
        end else if (drain) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_inst_q     <= NOP_INST;
            id_pc_q       <= 32'd0;
            id_pc4_q      <= 32'd0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            id_pc4_q      <= id_pc4_d;
            halted_q      <= halted_d;
            fetch_err_q   <= fetch_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign inst_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_pc4      = id_pc4_q;
    assign halted      = halted_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_count = fetch_count_q;

endmodule
